apb_fsm_controller: RTL and testbench

- Sequencing FSM of the AHB-to-APB bridge. Sits beside the AHB slave-side datapath, which supplies the address-range `valid` flag and the one-hot peripheral select `TEMP_SEL`.
- Converts accepted AHB transfers into APB SETUP/ENABLE cycles and drives HREADYout to stall the AHB master.
- Writes are posted; reads and back-to-back writes stall the master until completion. One pending-transfer buffer absorbs a transfer that arrives during a posted write.

---
 rtl/bridge_pkg.sv | 28 ++
 rtl/apb_pend_buf.sv | 52 +++++
 rtl/apb_fsm_controller.sv | 190 +++++++++++++++++++
 tb/tb_apb_fsm_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge.
package bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NSLV_DEF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE,
        ST_WRITEP,
        ST_WENABLEP
    } state_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/apb_pend_buf.sv
// One-entry buffer for a transfer accepted while a posted write is in flight.
module apb_pend_buf
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NSLV   = NSLV_DEF
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              ld_hdr_i,
    input  logic              ld_data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [NSLV-1:0]   sel_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [NSLV-1:0]   sel_o,
    output logic              wr_o,
    output logic [DATA_W-1:0] data_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [NSLV-1:0]   sel_q;
    logic              wr_q;
    logic [DATA_W-1:0] data_q;

    // Address-phase fields and data-phase word load on separate cycles.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            addr_q <= '0;
            sel_q  <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            if (ld_hdr_i) begin
                addr_q <= addr_i;
                sel_q  <= sel_i;
                wr_q   <= wr_i;
            end
            if (ld_data_i) begin
                data_q <= data_i;
            end
        end
    end

    assign addr_o = addr_q;
    assign sel_o  = sel_q;
    assign wr_o   = wr_q;
    assign data_o = data_q;

endmodule

// File: rtl/apb_fsm_controller.sv
// Sequencing FSM of the AHB-to-APB bridge: posts writes, stalls reads.
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NSLV   = NSLV_DEF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              valid,
    input  logic [1:0]        HTRANS,
    input  logic              HREADYin,
    input  logic              HWRITE,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic [NSLV-1:0]   TEMP_SEL,
    input  logic              PREADY,
    output logic [NSLV-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              HREADYout,
    output logic [1:0]        HRESP
);

    state_t            state_q, state_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [ADDR_W-1:0] aaddr_q, aaddr_d;
    logic [NSLV-1:0]   asel_q, asel_d;

    logic              acc;
    logic              accept;
    logic              pend_ld_hdr, pend_ld_data;
    logic [ADDR_W-1:0] pend_addr;
    logic [NSLV-1:0]   pend_sel;
    logic              pend_wr;
    logic [DATA_W-1:0] pend_data;

    assign acc = valid & HREADYin & (|TEMP_SEL) &
                 ((htrans_t'(HTRANS) == HTRANS_NONSEQ) || (htrans_t'(HTRANS) == HTRANS_SEQ));

    apb_pend_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSLV   (NSLV)
    ) u_pend (
        .clk_i     (HCLK),
        .clr_i     (HRESET),
        .ld_hdr_i  (pend_ld_hdr),
        .ld_data_i (pend_ld_data),
        .addr_i    (HADDR),
        .sel_i     (TEMP_SEL),
        .wr_i      (HWRITE),
        .data_i    (HWDATA),
        .addr_o    (pend_addr),
        .sel_o     (pend_sel),
        .wr_o      (pend_wr),
        .data_o    (pend_data)
    );

    // State and registered APB outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            aaddr_q   <= '0;
            asel_q    <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            aaddr_q   <= aaddr_d;
            asel_q    <= asel_d;
        end
    end

    // Next-state, next-output and HREADYout decode.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        aaddr_d      = aaddr_q;
        asel_d       = asel_q;
        pend_ld_hdr  = 1'b0;
        pend_ld_data = 1'b0;
        accept       = 1'b0;
        HREADYout    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                accept = 1'b1;
            end
            ST_READ: begin
                HREADYout = 1'b0;
                penable_d = 1'b1;
                state_d   = ST_RENABLE;
            end
            ST_RENABLE, ST_WENABLE: begin
                HREADYout = PREADY;
                if (PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    accept    = 1'b1;
                end
            end
            ST_WWAIT: begin
                paddr_d  = aaddr_q;
                pwdata_d = HWDATA;
                psel_d   = asel_q;
                pwrite_d = 1'b1;
                if (acc) begin
                    pend_ld_hdr = 1'b1;
                    state_d     = ST_WRITEP;
                end else begin
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                HREADYout = 1'b0;
                penable_d = 1'b1;
                state_d   = ST_WENABLE;
            end
            ST_WRITEP: begin
                HREADYout    = 1'b0;
                pend_ld_data = 1'b1;
                penable_d    = 1'b1;
                state_d      = ST_WENABLEP;
            end
            ST_WENABLEP: begin
                HREADYout = 1'b0;
                if (PREADY) begin
                    penable_d = 1'b0;
                    paddr_d   = pend_addr;
                    psel_d    = pend_sel;
                    if (pend_wr) begin
                        pwdata_d = pend_data;
                        pwrite_d = 1'b1;
                        state_d  = ST_WRITE;
                    end else begin
                        pwrite_d = 1'b0;
                        state_d  = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared acceptance decode; a read start overrides the PSEL clear above.
        if (accept) begin
            if (acc && !HWRITE) begin
                paddr_d  = HADDR;
                psel_d   = TEMP_SEL;
                pwrite_d = 1'b0;
                state_d  = ST_READ;
            end else if (acc) begin
                aaddr_d  = HADDR;
                asel_d   = TEMP_SEL;
                state_d  = ST_WWAIT;
            end else begin
                state_d  = ST_IDLE;
            end
        end
    end

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign HRESP   = HRESP_OKAY;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller.
module tb_apb_fsm_controller;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 3;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              valid;
    logic [1:0]        HTRANS;
    logic              HREADYin;
    logic              HWRITE;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic [NSLV-1:0]   TEMP_SEL;
    logic              PREADY;
    logic [NSLV-1:0]   PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              HREADYout;
    logic [1:0]        HRESP;

    int n_assert = 0;
    int n_fail   = 0;

    apb_fsm_controller #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSLV   (NSLV)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .valid     (valid),
        .HTRANS    (HTRANS),
        .HREADYin  (HREADYin),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .TEMP_SEL  (TEMP_SEL),
        .PREADY    (PREADY),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .HREADYout (HREADYout),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_apb(input string tag, input logic [NSLV-1:0] sel, input logic en,
                           input logic wr, input logic [ADDR_W-1:0] addr);
        chk({tag, ".PSEL"},    64'(PSEL),    64'(sel));
        chk({tag, ".PENABLE"}, 64'(PENABLE), 64'(en));
        chk({tag, ".PWRITE"},  64'(PWRITE),  64'(wr));
        chk({tag, ".PADDR"},   64'(PADDR),   64'(addr));
    endtask

    task automatic drive_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [NSLV-1:0] sel);
        valid    = 1'b1;
        HTRANS   = 2'b10;
        HREADYin = 1'b1;
        HWRITE   = wr;
        HADDR    = addr;
        TEMP_SEL = sel;
    endtask

    task automatic bus_idle();
        valid    = 1'b0;
        HTRANS   = 2'b00;
        HWRITE   = 1'b0;
        TEMP_SEL = '0;
    endtask

    initial begin
        HRESET = 1'b1; valid = 1'b0; HTRANS = 2'b00; HREADYin = 1'b1; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; TEMP_SEL = '0; PREADY = 1'b1;

        // Reset state
        tick(); tick();
        chk_apb("rst", 3'b000, 1'b0, 1'b0, 32'h0);
        chk("rst.PWDATA", 64'(PWDATA), 64'h0);
        chk("rst.HREADYout", 64'(HREADYout), 64'h1);
        chk("rst.HRESP", 64'(HRESP), 64'h0);
        HRESET = 1'b0;

        // Single read, PREADY high
        drive_xfer(1'b0, 32'h4000_1004, 3'b010);
        chk("rd.idle_hready", 64'(HREADYout), 64'h1);
        tick();
        bus_idle();
        chk_apb("rd.setup", 3'b010, 1'b0, 1'b0, 32'h4000_1004);
        chk("rd.setup_hready", 64'(HREADYout), 64'h0);
        tick();
        chk_apb("rd.enable", 3'b010, 1'b1, 1'b0, 32'h4000_1004);
        chk("rd.enable_hready", 64'(HREADYout), 64'h1);
        tick();
        chk_apb("rd.done", 3'b000, 1'b0, 1'b0, 32'h4000_1004);
        chk("rd.done_hready", 64'(HREADYout), 64'h1);

        // Single posted write
        drive_xfer(1'b1, 32'h4000_2008, 3'b100);
        tick();
        bus_idle();
        HWDATA = 32'hDEAD_BEEF;
        chk("wr.wwait_hready", 64'(HREADYout), 64'h1);
        tick();
        chk_apb("wr.setup", 3'b100, 1'b0, 1'b1, 32'h4000_2008);
        chk("wr.setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        chk("wr.setup_hready", 64'(HREADYout), 64'h0);
        HWDATA = 32'h0;
        tick();
        chk_apb("wr.enable", 3'b100, 1'b1, 1'b1, 32'h4000_2008);
        chk("wr.enable_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        chk("wr.enable_hready", 64'(HREADYout), 64'h1);
        tick();
        chk("wr.done_psel", 64'(PSEL), 64'h0);
        chk("wr.done_penable", 64'(PENABLE), 64'h0);

        // Back-to-back writes through the pending buffer
        drive_xfer(1'b1, 32'h4000_0000, 3'b001);
        tick();
        drive_xfer(1'b1, 32'h4000_0004, 3'b001);
        HWDATA = 32'h11;
        chk("b2b.wwait_hready", 64'(HREADYout), 64'h1);
        tick();
        bus_idle();
        HWDATA = 32'h22;
        chk_apb("b2b.setup1", 3'b001, 1'b0, 1'b1, 32'h4000_0000);
        chk("b2b.setup1_pwdata", 64'(PWDATA), 64'h11);
        chk("b2b.writep_hready", 64'(HREADYout), 64'h0);
        tick();
        HWDATA = 32'h0;
        chk_apb("b2b.enable1", 3'b001, 1'b1, 1'b1, 32'h4000_0000);
        chk("b2b.enable1_pwdata", 64'(PWDATA), 64'h11);
        chk("b2b.wenablep_hready", 64'(HREADYout), 64'h0);
        tick();
        chk_apb("b2b.setup2", 3'b001, 1'b0, 1'b1, 32'h4000_0004);
        chk("b2b.setup2_pwdata", 64'(PWDATA), 64'h22);
        chk("b2b.setup2_hready", 64'(HREADYout), 64'h0);
        tick();
        chk_apb("b2b.enable2", 3'b001, 1'b1, 1'b1, 32'h4000_0004);
        chk("b2b.enable2_hready", 64'(HREADYout), 64'h1);
        tick();
        chk("b2b.done_psel", 64'(PSEL), 64'h0);

        // Write then pending read, PREADY low for three cycles in each ENABLE
        drive_xfer(1'b1, 32'h4000_2000, 3'b100);
        tick();
        drive_xfer(1'b0, 32'h4000_1000, 3'b010);
        HWDATA = 32'h33;
        PREADY = 1'b0;
        tick();
        bus_idle();
        chk_apb("wr_rd.wsetup", 3'b100, 1'b0, 1'b1, 32'h4000_2000);
        tick();
        chk_apb("wr_rd.wenable", 3'b100, 1'b1, 1'b1, 32'h4000_2000);
        chk("wr_rd.wenable_pwdata", 64'(PWDATA), 64'h33);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rd.wwait_hready", 64'(HREADYout), 64'h0);
            tick();
            chk_apb("wr_rd.whold", 3'b100, 1'b1, 1'b1, 32'h4000_2000);
        end
        PREADY = 1'b1;
        #1;
        chk("wr_rd.wdone_hready", 64'(HREADYout), 64'h0);
        tick();
        PREADY = 1'b0;
        chk_apb("wr_rd.rsetup", 3'b010, 1'b0, 1'b0, 32'h4000_1000);
        chk("wr_rd.rsetup_hready", 64'(HREADYout), 64'h0);
        tick();
        chk_apb("wr_rd.renable", 3'b010, 1'b1, 1'b0, 32'h4000_1000);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rd.rwait_hready", 64'(HREADYout), 64'h0);
            tick();
            chk_apb("wr_rd.rhold", 3'b010, 1'b1, 1'b0, 32'h4000_1000);
        end
        PREADY = 1'b1;
        #1;
        chk("wr_rd.rdone_hready", 64'(HREADYout), 64'h1);
        tick();
        chk("wr_rd.idle_psel", 64'(PSEL), 64'h0);
        chk("wr_rd.idle_hready", 64'(HREADYout), 64'h1);

        // Out-of-range address is ignored
        valid = 1'b0; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h5000_0000; TEMP_SEL = '0;
        tick();
        chk("oor.psel1", 64'(PSEL), 64'h0);
        chk("oor.hready1", 64'(HREADYout), 64'h1);
        tick();
        chk("oor.psel2", 64'(PSEL), 64'h0);
        chk("oor.penable2", 64'(PENABLE), 64'h0);
        chk("oor.hready2", 64'(HREADYout), 64'h1);
        bus_idle();

        // Reset in RENABLE with PREADY low
        PREADY = 1'b0;
        drive_xfer(1'b0, 32'h4000_1004, 3'b010);
        tick();
        bus_idle();
        tick();
        chk("rstmid.penable", 64'(PENABLE), 64'h1);
        chk("rstmid.hready", 64'(HREADYout), 64'h0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk_apb("rstmid.after", 3'b000, 1'b0, 1'b0, 32'h0);
        chk("rstmid.after_hready", 64'(HREADYout), 64'h1);
        PREADY = 1'b1;
        drive_xfer(1'b0, 32'h4000_1008, 3'b010);
        tick();
        bus_idle();
        chk_apb("rstmid.rsetup", 3'b010, 1'b0, 1'b0, 32'h4000_1008);
        tick();
        chk_apb("rstmid.renable", 3'b010, 1'b1, 1'b0, 32'h4000_1008);
        chk("rstmid.renable_hready", 64'(HREADYout), 64'h1);
        tick();
        chk("rstmid.done_psel", 64'(PSEL), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
